// File: rtl/alu_pkg.sv
// Shared ALU package: ALU operation codes, multiplier width constants and
// the sequencer state type. Used by alu_mul_seq and its interface.
package alu_pkg;

  // Operand / product width and the iteration counter width.
  localparam int N_BITS = 64;
  localparam int CNT_W  = $clog2(N_BITS);

  // ALU opt encodings.
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1100;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bundle between the execute-stage parent and the sequential multiplier:
// the request/response handshake plus the borrowed ALU bus.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1; start while ready=0 is dropped, never queued. done is a one-cycle
// pulse and product is valid in that same cycle, holding until the next done.
// The ALU bus is driven by the multiplier; alu_result is combinational from
// alu_in1/alu_in2/alu_opt and valid in the same cycle.
interface alu_mul_seq_if;
  logic                          start;
  logic [alu_pkg::N_BITS-1:0]    multiplicand;
  logic [alu_pkg::N_BITS-1:0]    multiplier;
  logic                          ready;
  logic                          done;
  logic [alu_pkg::N_BITS-1:0]    product;
  logic [alu_pkg::N_BITS-1:0]    alu_in1;
  logic [alu_pkg::N_BITS-1:0]    alu_in2;
  logic [3:0]                    alu_opt;
  logic [alu_pkg::N_BITS-1:0]    alu_result;

  // Parent side: issues requests and owns the ALU instance.
  modport master (
    output start, multiplicand, multiplier, alu_result,
    input  ready, done, product, alu_in1, alu_in2, alu_opt
  );

  // Multiplier side.
  modport slave (
    input  start, multiplicand, multiplier, alu_result,
    output ready, done, product, alu_in1, alu_in2, alu_opt
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier (low N bits of A*B) that sequences the
// shared datapath ALU instead of owning an adder. One partial product is
// accumulated per RUN cycle through ALU ADD; outside RUN the ALU bus idles
// at in1=in2=0, opt=AND.
//
// Optional build macro: ALU_MUL_EARLY_EXIT_EN -- stop RUN once the remaining
// multiplier bits are all zero, and skip RUN entirely when B==0.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus,
  output state_t       dbg_state
);

  state_t             state;
  logic [N_BITS-1:0]  acc;
  logic [N_BITS-1:0]  mcand;
  logic [N_BITS-1:0]  mplr;
  logic [CNT_W-1:0]   cnt;

  logic [N_BITS-1:0]  mcand_nx;
  logic [N_BITS-1:0]  mplr_nx;
  logic [N_BITS-1:0]  addend_nx;
  logic               last_step;
  logic               skip_run;

  assign dbg_state = state;

  // Next-iteration operands and the RUN termination / skip decisions. The
  // ALU inputs are registered, so the addend for the following cycle is
  // derived from the shifted registers ahead of time.
  always_comb begin
    mcand_nx  = mcand << 1;
    mplr_nx   = mplr >> 1;
    addend_nx = mplr_nx[0] ? mcand_nx : '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
    last_step = (cnt == CNT_W'(N_BITS - 1)) || (mplr_nx == '0);
    skip_run  = (bus.multiplier == '0);
`else
    last_step = (cnt == CNT_W'(N_BITS - 1));
    skip_run  = 1'b0;
`endif
  end

  // Sequencer FSM with registered handshake, result and ALU-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      cnt         <= '0;
      bus.ready   <= 1'b1;
      bus.done    <= 1'b0;
      bus.product <= '0;
      bus.alu_in1 <= '0;
      bus.alu_in2 <= '0;
      bus.alu_opt <= ALU_AND;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            acc   <= '0;
            mcand <= bus.multiplicand;
            mplr  <= bus.multiplier;
            cnt   <= '0;
            bus.ready <= 1'b0;
            if (skip_run) begin
              // Zero multiplier: the product is known without iterating.
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.product <= '0;
            end else begin
              // First RUN cycle adds 0 + (B[0] ? A : 0).
              state       <= RUN;
              bus.alu_in1 <= '0;
              bus.alu_in2 <= bus.multiplier[0] ? bus.multiplicand : '0;
              bus.alu_opt <= ALU_ADD;
            end
          end
        end

        RUN: begin
          acc   <= bus.alu_result;
          mcand <= mcand_nx;
          mplr  <= mplr_nx;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            // The sum produced this cycle is the final product.
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.product <= bus.alu_result;
            bus.alu_in1 <= '0;
            bus.alu_in2 <= '0;
            bus.alu_opt <= ALU_AND;
          end else begin
            bus.alu_in1 <= bus.alu_result;
            bus.alu_in2 <= addend_nx;
            bus.alu_opt <= ALU_ADD;
          end
        end

        DONE: begin
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          bus.done    <= 1'b0;
          bus.ready   <= 1'b1;
          bus.alu_in1 <= '0;
          bus.alu_in2 <= '0;
          bus.alu_opt <= ALU_AND;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: behavioural ALU on the borrowed bus, directed
// and random multiplications, scoreboard of expected products and done
// cycles, async reset abort, and dropped start pulses while busy.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int N = N_BITS;

  logic clk;
  logic rst_n;
  state_t dbg_state;

  alu_mul_seq_if bus();

  alu_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] cyc;
  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 64'd1;

  // ---------------- behavioural ALU ----------------
  always_comb begin
    case (bus.alu_opt)
      ALU_AND:   bus.alu_result = bus.alu_in1 & bus.alu_in2;
      ALU_OR:    bus.alu_result = bus.alu_in1 | bus.alu_in2;
      ALU_ADD:   bus.alu_result = bus.alu_in1 + bus.alu_in2;
      ALU_SUB:   bus.alu_result = bus.alu_in1 - bus.alu_in2;
      ALU_PASSB: bus.alu_result = bus.alu_in2;
      ALU_XOR:   bus.alu_result = bus.alu_in1 ^ bus.alu_in2;
      default:   bus.alu_result = '0;
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  logic [63:0]  exp_cyc_q[$];
  logic [N-1:0] last_product;
  logic [63:0]  last_done_cyc;
  bit           busy;
  int           tests;
  int           failed;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: number of cycles spent in RUN for a given multiplier.
  function automatic int run_len(input logic [N-1:0] b);
    int r;
`ifdef ALU_MUL_EARLY_EXIT_EN
    r = 0;
    for (int i = 0; i < N; i++) if (b[i]) r = i + 1;
`else
    r = N;
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit check_b2b);
    int waited;
    logic [N-1:0] p;
    waited = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ready !== 1'b1) begin
      check64("ready_timeout", {63'd0, bus.ready}, 64'd1);
    end else begin
      bus.start = 1'b1;
      bus.multiplicand = a;
      bus.multiplier = b;
      @(posedge clk);
      #1;
      if (check_b2b) check64("b2b_accept_cycle", cyc, last_done_cyc + 64'd2);
      p = a * b;
      exp_q.push_back(p);
      exp_cyc_q.push_back(cyc + 64'(run_len(b)));
      busy = 1'b1;
      bus.start = 1'b0;
      bus.multiplicand = {$urandom, $urandom};
      bus.multiplier = {$urandom, $urandom};
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((busy || bus.ready !== 1'b1) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (busy || bus.ready !== 1'b1) check64("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check64("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [N-1:0] e;
          logic [63:0]  ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check64("product", bus.product, e);
          check64("done_cycle", cyc, ec);
          last_product  = e;
          last_done_cyc = cyc;
        end
        busy = 1'b0;
      end else begin
        check64("product_hold", bus.product, last_product);
        if (busy) check64("ready_low_busy", {63'd0, bus.ready}, 64'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    tests = 0;
    failed = 0;
    busy = 1'b0;
    last_product = '0;
    last_done_cyc = '0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    rst_n = 1'b0;

    // Reset values.
    #23;
    check64("rst_ready", {63'd0, bus.ready}, 64'd1);
    check64("rst_done", {63'd0, bus.done}, 64'd0);
    check64("rst_product", bus.product, 64'd0);
    check64("rst_alu_in1", bus.alu_in1, 64'd0);
    check64("rst_alu_in2", bus.alu_in2, 64'd0);
    check64("rst_alu_opt", {60'd0, bus.alu_opt}, 64'd0);
    check64("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    issue(64'd3, 64'd5, 1'b0);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0);
    wait_idle();
    issue(64'd7, 64'd0, 1'b0);
    wait_idle();

    // Start pulses while busy are dropped; first result must be intact.
    issue(64'd11, 64'h8000_0000_0000_0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b0) begin
        bus.start = 1'b1;
        bus.multiplicand = {$urandom, $urandom};
        bus.multiplier = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Random back-to-back operations.
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b = b >> $urandom_range(0, 63);
      if ($urandom_range(0, 4) == 0) b = '0;
      issue(a, b, i > 0);
    end
    wait_idle();

    // Reset at RUN cycle 10 aborts the operation.
    issue(64'd123, 64'hF000_0000_0000_0001, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check64("abort_ready", {63'd0, bus.ready}, 64'd1);
    check64("abort_done", {63'd0, bus.done}, 64'd0);
    check64("abort_product", bus.product, 64'd0);
    check64("abort_alu_opt", {60'd0, bus.alu_opt}, 64'd0);
    check64("abort_alu_in1", bus.alu_in1, 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    busy = 1'b0;
    last_product = '0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'd6, 64'd7, 1'b0);
    wait_idle();

    check64("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
